// File: rtl/perf_monitor.sv
// Retirement performance monitor: saturating event counters plus a small
// IDLE/RUN/DONE/HUNG tracker that detects program end (PC spin) and hangs.
module perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int HANG_CYCLES = 1024,
  parameter int HALT_REPEAT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_pc_debug,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic             i_clr,
  input  logic [1:0]       i_sel,
  output logic [CNT_W-1:0] o_rdata,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_hang
);

  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam int IW = $clog2(HANG_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HUNG = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cyc_q, insn_q, ctrl_q, mis_q, rdata_q;
  logic [31:0]      last_pc_q;
  logic [RW-1:0]    rep_q, rep_d;
  logic [IW-1:0]    idle_q;
  logic             active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // DONE and HUNG freeze everything; only IDLE and RUN observe retirements.
  assign active = (state_q == S_IDLE) || (state_q == S_RUN);
  assign rep_d  = (i_pc_debug == last_pc_q) ? rep_q + RW'(1) : RW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      insn_q    <= '0;
      ctrl_q    <= '0;
      mis_q     <= '0;
      rdata_q   <= '0;
      last_pc_q <= '0;
      rep_q     <= '0;
      idle_q    <= '0;
    end else begin
      // Readout captures the pre-update counter value.
      case (i_sel)
        2'd0:    rdata_q <= cyc_q;
        2'd1:    rdata_q <= insn_q;
        2'd2:    rdata_q <= ctrl_q;
        default: rdata_q <= mis_q;
      endcase
      if (i_clr) begin
        state_q   <= S_IDLE;
        cyc_q     <= '0;
        insn_q    <= '0;
        ctrl_q    <= '0;
        mis_q     <= '0;
        last_pc_q <= '0;
        rep_q     <= '0;
        idle_q    <= '0;
      end else if (active) begin
        if (state_q == S_RUN || i_insn_vld) cyc_q <= sat_inc(cyc_q);
        if (i_insn_vld) begin
          insn_q    <= sat_inc(insn_q);
          if (i_ctrl)    ctrl_q <= sat_inc(ctrl_q);
          if (i_mispred) mis_q  <= sat_inc(mis_q);
          last_pc_q <= i_pc_debug;
          rep_q     <= rep_d;
          idle_q    <= '0;
          if (state_q == S_IDLE)               state_q <= S_RUN;
          else if (rep_d == RW'(HALT_REPEAT))  state_q <= S_DONE;
        end else if (state_q == S_RUN) begin
          idle_q <= idle_q + IW'(1);
          if (idle_q == IW'(HANG_CYCLES - 1)) state_q <= S_HUNG;
        end
      end
    end
  end

  assign o_rdata = rdata_q;
  assign o_state = state_q;
  assign o_done  = (state_q == S_DONE);
  assign o_hang  = (state_q == S_HUNG);

endmodule

// File: tb/tb_perf_monitor.sv
// Randomized and directed bench for perf_monitor, checked against an
// unsaturated event-count model that saturates only on readout.
module tb_perf_monitor;
  localparam int HANG = 8;
  localparam int HALT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        vld, ctrl, mis, clr;
  logic [1:0]  sel;
  logic [31:0] rdata;
  logic [1:0]  state;
  logic        done, hang;
  logic [3:0]  rdata4;
  logic [1:0]  state4;
  logic        done4, hang4;

  int checks = 0;
  int errors = 0;

  // model
  longint      m_cnt[4];
  int          m_st;
  logic [31:0] m_pc;
  int          m_rep, m_idle;
  logic [31:0] exp_rd;
  logic [3:0]  exp_rd4;

  perf_monitor #(.CNT_W(32), .HANG_CYCLES(HANG), .HALT_REPEAT(HALT)) dut (
    .i_clk(clk), .i_reset(rst), .i_pc_debug(pc), .i_insn_vld(vld),
    .i_ctrl(ctrl), .i_mispred(mis), .i_clr(clr), .i_sel(sel),
    .o_rdata(rdata), .o_state(state), .o_done(done), .o_hang(hang));

  perf_monitor #(.CNT_W(4), .HANG_CYCLES(HANG), .HALT_REPEAT(HALT)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_pc_debug(pc), .i_insn_vld(vld),
    .i_ctrl(ctrl), .i_mispred(mis), .i_clr(clr), .i_sel(sel),
    .o_rdata(rdata4), .o_state(state4), .o_done(done4), .o_hang(hang4));

  always #5 clk = ~clk;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_st = 0; m_pc = '0; m_rep = 0; m_idle = 0;
  endfunction

  // One clock: drive inputs, advance the model, return #1 after the edge.
  task automatic cyc(input logic v, input logic [31:0] p, input logic c,
                     input logic mp, input logic cl, input logic [1:0] s);
    vld = v; pc = p; ctrl = c; mis = mp; clr = cl; sel = s;
    exp_rd  = 32'(sat(m_cnt[s], 64'hffff_ffff));
    exp_rd4 = 4'(sat(m_cnt[s], 15));
    if (cl) m_clear();
    else if (m_st == 1 || (m_st == 0 && v)) begin
      m_cnt[0]++;
      if (v) begin
        m_cnt[1]++;
        if (c)  m_cnt[2]++;
        if (mp) m_cnt[3]++;
        m_rep  = (p == m_pc) ? m_rep + 1 : 1;
        m_pc   = p;
        m_idle = 0;
        if (m_st == 0)          m_st = 1;
        else if (m_rep == HALT) m_st = 2;
      end else begin
        m_idle++;
        if (m_idle == HANG) m_st = 3;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (state !== 2'd0 || done !== 1'b0 || hang !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got st=%0d d=%0b h=%0b want 0", state, done, hang);
    end
    checks++; if (rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %0h want 0", rdata);
    end
    rst = 1'b0;
    m_clear();
    for (int s = 0; s < 4; s++) begin
      cyc(0, 0, 0, 0, 0, 2'(s));
      checks++; if (rdata !== 32'd0) begin
        errors++; $display("FAIL reset_cnt%0d: got %0h want 0", s, rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0);
    checks++; if (state !== 2'd1) begin
      errors++; $display("FAIL b2b_state: got %0d want 1", state);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL b2b_cycles: got %0d want 10", rdata); end
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL b2b_insn: got %0d want 10", rdata); end
    cyc(0, 0, 0, 0, 0, 2);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL b2b_ctrl: got %0d want 0", rdata); end
  endtask

  task automatic test_ctrl();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h100, 1, 0, 0, 0);
    cyc(1, 32'h104, 1, 1, 0, 0);
    cyc(1, 32'h108, 1, 0, 0, 0);
    cyc(0, 32'h10c, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL ctrl_cnt: got %0d want 3", rdata); end
    cyc(0, 0, 0, 0, 0, 3);
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL mispred_cnt: got %0d want 1", rdata); end
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL ctrl_insn: got %0d want 3", rdata); end
  endtask

  task automatic test_done();
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'h40, 0, 0, 0, 1);
      checks++; if (done !== (k == 3)) begin
        errors++; $display("FAIL done_after_%0d: got %0b want %0b", k + 1, done, k == 3);
      end
      if (k < 3) for (int g = 0; g <= k; g++) cyc(0, 0, 0, 0, 0, 1);
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL done_state: got %0d want 2", state); end
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata !== 32'd4) begin errors++; $display("FAIL done_insn: got %0d want 4", rdata); end
    for (int k = 0; k < 3; k++) cyc(1, 32'h44 + 32'(k), 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata !== 32'd4 || done !== 1'b1) begin
      errors++; $display("FAIL done_frozen: got insn=%0d done=%0b want 4/1", rdata, done);
    end
  endtask

  task automatic test_hang();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h200, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0);
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_7idle: got %0b want 0", hang); end
    cyc(1, 32'h204, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0);
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_early: got %0b want 0", hang); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (hang !== 1'b1 || state !== 2'd3) begin
      errors++; $display("FAIL hang_8idle: got h=%0b st=%0d want 1/3", hang, state);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (rdata !== 32'd17) begin errors++; $display("FAIL hang_cycles: got %0d want 17", rdata); end
    for (int i = 0; i < 3; i++) cyc(1, 32'h208, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (rdata !== 32'd17) begin errors++; $display("FAIL hang_frozen: got %0d want 17", rdata); end
  endtask

  task automatic test_clr_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + 32'(4 * i), 1, 1, 0, 0);
    cyc(1, 32'h310, 1, 1, 1, 1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL clr_state: got %0d want 0", state); end
    for (int s = 0; s < 4; s++) begin
      cyc(0, 0, 0, 0, 0, 2'(s));
      checks++; if (rdata !== 32'd0) begin
        errors++; $display("FAIL clr_cnt%0d: got %0d want 0", s, rdata);
      end
    end
    cyc(1, 32'h400, 0, 0, 0, 1);
    cyc(1, 32'h404, 0, 0, 0, 1);
    cyc(1, 32'h408, 0, 0, 0, 1);
    rst = 1'b1;
    #2;
    checks++; if (rdata !== 32'd0 || state !== 2'd0 || done !== 1'b0 || hang !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rd=%0h st=%0d d=%0b h=%0b want 0", rdata, state, done, hang);
    end
    rst = 1'b0;
    m_clear();
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_discard: got %0d want 0", rdata); end
  endtask

  task automatic test_random();
    int vld_pct;
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) vld_pct = (($urandom_range(0, 2) == 0) ? 8 : 70);
      cyc(($urandom_range(0, 99) < vld_pct), 32'h1000 + 32'(4 * $urandom_range(0, 2)),
          1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), 2'($urandom));
      checks++; if (rdata !== exp_rd) begin
        errors++; $display("FAIL rnd_rdata@%0d: got %0h want %0h", i, rdata, exp_rd);
      end
      checks++; if (rdata4 !== exp_rd4) begin
        errors++; $display("FAIL rnd_rdata4@%0d: got %0h want %0h", i, rdata4, exp_rd4);
      end
      checks++; if (state !== 2'(m_st) || done !== (m_st == 2) || hang !== (m_st == 3) || state4 !== state) begin
        errors++; $display("FAIL rnd_state@%0d: got %0d/%0b/%0b want %0d", i, state, done, hang, m_st);
      end
    end
  endtask

  task automatic test_saturate();
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(1, 32'h500 + 32'(4 * i), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    checks++; if (rdata4 !== 4'd15) begin errors++; $display("FAIL sat_insn4: got %0d want 15", rdata4); end
    checks++; if (rdata !== 32'd20) begin errors++; $display("FAIL sat_insn32: got %0d want 20", rdata); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (rdata4 !== 4'd15) begin errors++; $display("FAIL sat_cyc4: got %0d want 15", rdata4); end
  endtask

  initial begin
    rst = 1'b1; vld = 0; pc = '0; ctrl = 0; mis = 0; clr = 0; sel = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_ctrl();
    test_done();
    test_hang();
    test_clr_reset();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
